rob_nway: RTL and testbench
===========================

# rob_nway

Parametrised N-way reorder buffer, successor to the fixed 2-way ROB. Sits between dispatch and the architectural map/free list. Each cycle it:
- allocates up to `WAYS` entries in program order;
- marks entries done from `CDB_NUM` completion buses;
- retires up to `WAYS` consecutive done entries from the head.

Unlike the 2-way ROB, it reports free-slot count and per-lane tags, and performs a full flush on a retiring branch mispredict.

## Interface
- `ROB_SIZE`, 32: entries; power of two, ≥ 2×`WAYS`. `ROB_LEN` = log2(`ROB_SIZE`).
- `WAYS`, 2: dispatch and retire lanes.
- `CDB_NUM`, 2: completion buses.
- `AR_LEN` 5, `PR_LEN` 6, `PC_LEN` 32, `FU_LEN` 3: field widths.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `dispatch_valid_in` in `WAYS`: lane i carries an instruction.
- `arch_reg_in`, `phy_reg_in`, `pc_in`, `fu_in` in `WAYS`×field: per-lane payload; lane i at bits [i*W +: W].
- `pred_taken_in`, `is_branch_in` in `WAYS`: per-lane prediction and branch flag.
- `cdb_valid_in` in `CDB_NUM`: completion valid.
- `cdb_tag_in` in `CDB_NUM`×`ROB_LEN`: ROB index completing.
- `cdb_branch_rst_in` in `CDB_NUM`: actual branch direction.
- `dispatch_tag_out` out `WAYS`×`ROB_LEN`: tag assigned to lane i this cycle.
- `free_slots_out` out `ROB_LEN`+1: `ROB_SIZE` − occupancy (registered).
- `full_out` out 1: `free_slots_out` == 0.
- `head_out`, `tail_out` out `ROB_LEN`: pointers.
- `retire_valid_out` out `WAYS`: lane j retiring this cycle.
- `retire_arch_reg_out`, `retire_phy_reg_out`, `retire_pc_out` out `WAYS`×field: retiring entry fields.
- `mispred_out` out 1: retiring branch mispredicted; flush at next edge.
- `mispred_pc_out` out `PC_LEN`: PC of that branch.

## Operation
**Entry state:** valid, pc, fu, arch_reg, phy_reg, pred_taken, is_branch, done, branch_rst.

**Dispatch:**
- Lane i is assigned tag `tail` + (number of valid lanes below i), mod `ROB_SIZE`. Tags are compacted.
- `dispatch_tag_out` is combinational from `tail` and `dispatch_valid_in`.
- If popcount(`dispatch_valid_in`) > `free_slots_out`, the whole group is ignored: nothing written, `tail` unchanged. The dispatcher must gate.
- Accepted entries are written with done=0 and branch_rst=0; `tail` advances by popcount.

**Completion:**
- A valid `cdb_tag_in` hitting a valid entry sets done=1 and branch_rst at the edge.
- A tag hitting an invalid entry is ignored.
- Two buses with the same tag: done=1; branch_rst is taken from the lowest-index bus.

**Retire:**
- Combinational from registered state.
- Lane j retires entry `head`+j iff that entry is valid and done, and all lanes < j retire.
- Mispredict: an entry with is_branch && pred_taken != branch_rst.
  - It retires in its lane; all higher lanes get `retire_valid_out` = 0 that cycle.
  - `mispred_out` = 1 and `mispred_pc_out` = its pc.

**Flush** (edge following `mispred_out` = 1):
- All valid bits cleared; `head` = `tail` = 0; `free_slots_out` = `ROB_SIZE`.
- Same-cycle dispatch and CDB writes are discarded.

**Occupancy:** count' = count + accepted − retired; `free_slots_out` is registered and does not credit same-cycle retirement.

**Pointers:** wrap modulo `ROB_SIZE`. Occupancy = `ROB_SIZE` is distinguished from empty by the count, not by pointer equality.

## Timing
- Reset values: `head_out` = `tail_out` = 0, `free_slots_out` = `ROB_SIZE`, `full_out` = 0, all entries invalid, `retire_valid_out` = 0, `mispred_out` = 0, `mispred_pc_out` = 0, retire fields 0.
- Reset asserted mid-operation: identical state at the next edge, overrides flush/dispatch/CDB.
- Dispatch in cycle n: entry visible in cycle n+1.
- CDB in cycle n: done visible in cycle n+1, earliest retire n+1. There is no CDB-to-retire bypass.
- Retire outputs and `mispred_out` are valid in the same cycle as the registered done state; `head` advances at that edge.
- Full ROB with a simultaneous retire: dispatch still rejected that cycle, accepted the next.
- Wrap: dispatch group straddling index `ROB_SIZE`−1 → 0 assigns consecutive tags mod `ROB_SIZE`.

## Test plan
- Reset, then dispatch 2 lanes for 4 cycles (`ROB_SIZE`=8, `WAYS`=2) → tags 0..7, `free_slots_out` 8→0, `full_out` = 1; a 5th group is ignored and `tail_out` stays 0.
- CDB tags 1 then 0 in consecutive cycles → no retire after tag 1; after tag 0 completes, both retire in one cycle with `retire_valid_out` = 2'b11 and `head_out` 0→2.
- `dispatch_valid_in` = 2'b10 with `tail` = 7 → lane1 tag 7, `tail_out` = 0; next group gets tags 0,1 (wrap).
- Branch at head with pred_taken = 0 completes with branch_rst = 1, younger entry also done → `mispred_out` = 1, only lane0 retires, `mispred_pc_out` = branch pc; next cycle all invalid, `head_out` = `tail_out` = 0, `free_slots_out` = 8.
- Both CDBs carry tag 3 with branch_rst 1/0 → entry 3 done, branch_rst = 1.
- Reset asserted while 5 entries are valid and a dispatch is in flight → next cycle: empty, `free_slots_out` = 8, all outputs at reset values.

Source files
------------

// File: rtl/rob_nway.sv
// N-way reorder buffer: in-order allocate and retire of up to WAYS entries per cycle,
// with out-of-order completion from CDB_NUM buses and a full flush on a retiring mispredict.
module rob_nway #(
    parameter int ROB_SIZE = 32,
    parameter int WAYS     = 2,
    parameter int CDB_NUM  = 2,
    parameter int AR_LEN   = 5,
    parameter int PR_LEN   = 6,
    parameter int PC_LEN   = 32,
    parameter int FU_LEN   = 3,
    localparam int ROB_LEN = $clog2(ROB_SIZE)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WAYS-1:0]           dispatch_valid_in,
    input  logic [WAYS*AR_LEN-1:0]    arch_reg_in,
    input  logic [WAYS*PR_LEN-1:0]    phy_reg_in,
    input  logic [WAYS*PC_LEN-1:0]    pc_in,
    input  logic [WAYS*FU_LEN-1:0]    fu_in,
    input  logic [WAYS-1:0]           pred_taken_in,
    input  logic [WAYS-1:0]           is_branch_in,
    input  logic [CDB_NUM-1:0]        cdb_valid_in,
    input  logic [CDB_NUM*ROB_LEN-1:0] cdb_tag_in,
    input  logic [CDB_NUM-1:0]        cdb_branch_rst_in,
    output logic [WAYS*ROB_LEN-1:0]   dispatch_tag_out,
    output logic [ROB_LEN:0]          free_slots_out,
    output logic                      full_out,
    output logic [ROB_LEN-1:0]        head_out,
    output logic [ROB_LEN-1:0]        tail_out,
    output logic [WAYS-1:0]           retire_valid_out,
    output logic [WAYS*AR_LEN-1:0]    retire_arch_reg_out,
    output logic [WAYS*PR_LEN-1:0]    retire_phy_reg_out,
    output logic [WAYS*PC_LEN-1:0]    retire_pc_out,
    output logic                      mispred_out,
    output logic [PC_LEN-1:0]         mispred_pc_out
);

    localparam int CNT_W = ROB_LEN + 1;

    logic [ROB_SIZE-1:0] valid;
    logic [ROB_SIZE-1:0] done;
    logic [ROB_SIZE-1:0] branch_rst;
    logic [ROB_SIZE-1:0] pred_taken;
    logic [ROB_SIZE-1:0] is_branch;
    logic [PC_LEN-1:0]   pc       [ROB_SIZE];
    logic [AR_LEN-1:0]   arch_reg [ROB_SIZE];
    logic [PR_LEN-1:0]   phy_reg  [ROB_SIZE];
    logic [FU_LEN-1:0]   fu       [ROB_SIZE];

    logic [ROB_LEN-1:0] head;
    logic [ROB_LEN-1:0] tail;
    logic [CNT_W-1:0]   free_slots;

    logic [ROB_LEN-1:0] lane_tag [WAYS];
    logic [CNT_W-1:0]   dispatch_cnt;
    logic [CNT_W-1:0]   retire_cnt;
    logic               accept;
    logic [ROB_LEN-1:0] retire_idx;
    logic               retire_blocked;
    logic               unused_head_fu;

    assign head_out       = head;
    assign tail_out       = tail;
    assign free_slots_out = free_slots;
    assign full_out       = (free_slots == '0);

    // The FU class travels with the entry but nothing downstream of retire consumes it.
    assign unused_head_fu = ^fu[head];

    // Tags are compacted: each valid lane takes the next slot after the valid lanes below it.
    always_comb begin
        dispatch_cnt     = '0;
        dispatch_tag_out = '0;
        for (int i = 0; i < WAYS; i++) begin
            lane_tag[i] = tail + dispatch_cnt[ROB_LEN-1:0];
            dispatch_tag_out[i*ROB_LEN +: ROB_LEN] = lane_tag[i];
            dispatch_cnt = dispatch_cnt + CNT_W'(dispatch_valid_in[i]);
        end
    end

    assign accept = (dispatch_cnt <= free_slots);

    always_comb begin
        retire_valid_out    = '0;
        retire_arch_reg_out = '0;
        retire_phy_reg_out  = '0;
        retire_pc_out       = '0;
        mispred_out         = 1'b0;
        mispred_pc_out      = '0;
        retire_cnt          = '0;
        retire_blocked      = 1'b0;
        retire_idx          = '0;
        for (int j = 0; j < WAYS; j++) begin
            retire_idx = head + ROB_LEN'(j);
            if (!retire_blocked && valid[retire_idx] && done[retire_idx]) begin
                retire_valid_out[j] = 1'b1;
                retire_arch_reg_out[j*AR_LEN +: AR_LEN] = arch_reg[retire_idx];
                retire_phy_reg_out[j*PR_LEN +: PR_LEN]  = phy_reg[retire_idx];
                retire_pc_out[j*PC_LEN +: PC_LEN]       = pc[retire_idx];
                retire_cnt = retire_cnt + CNT_W'(1);
                // A mispredicted branch retires itself but nothing younger.
                if (is_branch[retire_idx] && (pred_taken[retire_idx] != branch_rst[retire_idx])) begin
                    mispred_out    = 1'b1;
                    mispred_pc_out = pc[retire_idx];
                    retire_blocked = 1'b1;
                end
            end else begin
                retire_blocked = 1'b1;
            end
        end
    end

    // Reset and mispredict flush leave the same empty state and discard same-cycle writes.
    always_ff @(posedge clock) begin
        if (reset || mispred_out) begin
            valid      <= '0;
            head       <= '0;
            tail       <= '0;
            free_slots <= CNT_W'(ROB_SIZE);
        end else begin
            // Walking buses high to low lets the lowest-index bus win a shared tag.
            for (int k = CDB_NUM - 1; k >= 0; k--) begin
                if (cdb_valid_in[k] && valid[cdb_tag_in[k*ROB_LEN +: ROB_LEN]]) begin
                    done[cdb_tag_in[k*ROB_LEN +: ROB_LEN]]       <= 1'b1;
                    branch_rst[cdb_tag_in[k*ROB_LEN +: ROB_LEN]] <= cdb_branch_rst_in[k];
                end
            end
            for (int j = 0; j < WAYS; j++) begin
                if (retire_valid_out[j]) begin
                    valid[head + ROB_LEN'(j)] <= 1'b0;
                end
            end
            if (accept) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (dispatch_valid_in[i]) begin
                        valid[lane_tag[i]]      <= 1'b1;
                        done[lane_tag[i]]       <= 1'b0;
                        branch_rst[lane_tag[i]] <= 1'b0;
                        pred_taken[lane_tag[i]] <= pred_taken_in[i];
                        is_branch[lane_tag[i]]  <= is_branch_in[i];
                        pc[lane_tag[i]]         <= pc_in[i*PC_LEN +: PC_LEN];
                        arch_reg[lane_tag[i]]   <= arch_reg_in[i*AR_LEN +: AR_LEN];
                        phy_reg[lane_tag[i]]    <= phy_reg_in[i*PR_LEN +: PR_LEN];
                        fu[lane_tag[i]]         <= fu_in[i*FU_LEN +: FU_LEN];
                    end
                end
                tail <= tail + dispatch_cnt[ROB_LEN-1:0];
            end
            head       <= head + retire_cnt[ROB_LEN-1:0];
            free_slots <= free_slots - (accept ? dispatch_cnt : '0) + retire_cnt;
        end
    end

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway (8 entries, 2 ways, 2 CDBs) with a queue-based
// reference model compared every cycle plus hand-computed literal checkpoints.
module tb_rob_nway;

    localparam int RS = 8;
    localparam int RL = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  dispatch_valid_in;
    logic [9:0]  arch_reg_in;
    logic [11:0] phy_reg_in;
    logic [63:0] pc_in;
    logic [5:0]  fu_in;
    logic [1:0]  pred_taken_in;
    logic [1:0]  is_branch_in;
    logic [1:0]  cdb_valid_in;
    logic [5:0]  cdb_tag_in;
    logic [1:0]  cdb_branch_rst_in;
    logic [5:0]  dispatch_tag_out;
    logic [3:0]  free_slots_out;
    logic        full_out;
    logic [2:0]  head_out;
    logic [2:0]  tail_out;
    logic [1:0]  retire_valid_out;
    logic [9:0]  retire_arch_reg_out;
    logic [11:0] retire_phy_reg_out;
    logic [63:0] retire_pc_out;
    logic        mispred_out;
    logic [31:0] mispred_pc_out;

    int total_checks = 0;
    int bad_checks   = 0;
    int ser          = 0;
    bit started      = 1'b0;
    logic [31:0] br_pc;

    rob_nway #(.ROB_SIZE(RS), .WAYS(2), .CDB_NUM(2)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid_in(dispatch_valid_in), .arch_reg_in(arch_reg_in),
        .phy_reg_in(phy_reg_in), .pc_in(pc_in), .fu_in(fu_in),
        .pred_taken_in(pred_taken_in), .is_branch_in(is_branch_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
        .cdb_branch_rst_in(cdb_branch_rst_in),
        .dispatch_tag_out(dispatch_tag_out), .free_slots_out(free_slots_out),
        .full_out(full_out), .head_out(head_out), .tail_out(tail_out),
        .retire_valid_out(retire_valid_out), .retire_arch_reg_out(retire_arch_reg_out),
        .retire_phy_reg_out(retire_phy_reg_out), .retire_pc_out(retire_pc_out),
        .mispred_out(mispred_out), .mispred_pc_out(mispred_pc_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [4:0]  ar;
        logic [5:0]  pr;
        bit          br;
        bit          pt;
        bit          done;
        bit          brst;
    } ent_t;

    // Program-order queue of live entries; front is the oldest.
    ent_t rob_q[$];
    int   m_head = 0;
    int   m_tail = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic void model_retire(output logic [1:0] rv, output int n,
                                         output bit mp, output logic [31:0] mpc);
        rv = 2'b00; n = 0; mp = 1'b0; mpc = '0;
        for (int j = 0; j < 2 && j < rob_q.size(); j++) begin
            if (!rob_q[j].done) break;
            rv[j] = 1'b1;
            n++;
            if (rob_q[j].br && (rob_q[j].pt != rob_q[j].brst)) begin
                mp  = 1'b1;
                mpc = rob_q[j].pc;
                break;
            end
        end
    endfunction

    always @(posedge clock) begin
        logic [1:0]  rv;
        int          n;
        bit          mp;
        logic [31:0] mpc;
        int          lanes;
        int          free_before;
        int          off;
        ent_t        ne;
        model_retire(rv, n, mp, mpc);
        if (reset) started = 1'b1;
        if (reset || mp) begin
            rob_q.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            for (int e = 0; e < rob_q.size(); e++) begin
                for (int k = 0; k < 2; k++) begin
                    if (cdb_valid_in[k] && int'(cdb_tag_in[k*RL +: RL]) == rob_q[e].tag) begin
                        rob_q[e].done = 1'b1;
                        rob_q[e].brst = cdb_branch_rst_in[k];
                        break;
                    end
                end
            end
            free_before = RS - rob_q.size();
            repeat (n) void'(rob_q.pop_front());
            m_head = (m_head + n) % RS;
            lanes = $countones(dispatch_valid_in);
            if (lanes <= free_before) begin
                off = 0;
                for (int i = 0; i < 2; i++) begin
                    if (dispatch_valid_in[i]) begin
                        ne.tag  = (m_tail + off) % RS;
                        ne.pc   = pc_in[i*32 +: 32];
                        ne.ar   = arch_reg_in[i*5 +: 5];
                        ne.pr   = phy_reg_in[i*6 +: 6];
                        ne.br   = is_branch_in[i];
                        ne.pt   = pred_taken_in[i];
                        ne.done = 1'b0;
                        ne.brst = 1'b0;
                        rob_q.push_back(ne);
                        off++;
                    end
                end
                m_tail = (m_tail + lanes) % RS;
            end
        end
    end

    always @(negedge clock) begin
        logic [5:0]  exp_tags;
        logic [1:0]  rv;
        int          n;
        bit          mp;
        logic [31:0] mpc;
        logic [9:0]  exp_ar;
        logic [11:0] exp_pr;
        logic [63:0] exp_pc;
        int          off;
        if (started) begin
            off = 0;
            for (int i = 0; i < 2; i++) begin
                exp_tags[i*RL +: RL] = 3'((m_tail + off) % RS);
                if (dispatch_valid_in[i]) off++;
            end
            model_retire(rv, n, mp, mpc);
            exp_ar = '0; exp_pr = '0; exp_pc = '0;
            for (int j = 0; j < 2; j++) begin
                if (rv[j]) begin
                    exp_ar[j*5 +: 5]   = rob_q[j].ar;
                    exp_pr[j*6 +: 6]   = rob_q[j].pr;
                    exp_pc[j*32 +: 32] = rob_q[j].pc;
                end
            end
            checkOutput("dispatch_tag", 64'(dispatch_tag_out), 64'(exp_tags));
            checkOutput("free_slots", 64'(free_slots_out), 64'(RS - rob_q.size()));
            checkOutput("full", 64'(full_out), 64'(rob_q.size() == RS));
            checkOutput("head", 64'(head_out), 64'(m_head));
            checkOutput("tail", 64'(tail_out), 64'(m_tail));
            checkOutput("retire_valid", 64'(retire_valid_out), 64'(rv));
            checkOutput("retire_arch", 64'(retire_arch_reg_out), 64'(exp_ar));
            checkOutput("retire_phy", 64'(retire_phy_reg_out), 64'(exp_pr));
            checkOutput("retire_pc", retire_pc_out, exp_pc);
            checkOutput("mispred", 64'(mispred_out), 64'(mp));
            checkOutput("mispred_pc", 64'(mispred_pc_out), 64'(mpc));
        end
    end

    task automatic applyStimulus(input logic [1:0] dv, input logic [1:0] br, input logic [1:0] pt,
                                 input logic [1:0] cv, input logic [5:0] ctag,
                                 input logic [1:0] crst, input logic rst);
        reset             = rst;
        dispatch_valid_in = dv;
        is_branch_in      = br;
        pred_taken_in     = pt;
        cdb_valid_in      = cv;
        cdb_tag_in        = ctag;
        cdb_branch_rst_in = crst;
        for (int i = 0; i < 2; i++) begin
            int n;
            n = ser * 2 + i;
            pc_in[i*32 +: 32]      = 32'h1000 + 32'(n * 4);
            arch_reg_in[i*5 +: 5]  = 5'(n);
            phy_reg_in[i*6 +: 6]   = 6'(n + 7);
            fu_in[i*3 +: 3]        = 3'(n);
        end
        ser++;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drainAll();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 6'b011_010, 2'b00, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 6'b101_100, 2'b00, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 6'b111_110, 2'b00, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 6'b001_000, 2'b00, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        tick();
    endtask

    initial begin
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b1);
        tick();
        tick();
        checkOutput("lit_reset_head", 64'(head_out), 64'd0);
        checkOutput("lit_reset_tail", 64'(tail_out), 64'd0);
        checkOutput("lit_reset_free", 64'(free_slots_out), 64'd8);
        checkOutput("lit_reset_full", 64'(full_out), 64'd0);
        checkOutput("lit_reset_rv", 64'(retire_valid_out), 64'd0);
        checkOutput("lit_reset_mispred", 64'(mispred_out), 64'd0);

        // Fill: four 2-lane groups take tags 0..7.
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_first_tags", 64'(dispatch_tag_out), 64'b001_000);
        tick();
        for (int g = 1; g < 4; g++) begin
            applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
            tick();
        end
        checkOutput("lit_full_free", 64'(free_slots_out), 64'd0);
        checkOutput("lit_full_flag", 64'(full_out), 64'd1);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        tick();
        checkOutput("lit_reject_tail", 64'(tail_out), 64'd0);

        // Out-of-order completion: tag 1 then tag 0.
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 6'b000_001, 2'b00, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 6'b000_000, 2'b00, 1'b0);
        checkOutput("lit_no_retire", 64'(retire_valid_out), 64'd0);
        tick();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_dual_retire", 64'(retire_valid_out), 64'b11);
        checkOutput("lit_head_before", 64'(head_out), 64'd0);
        tick();
        checkOutput("lit_head_after", 64'(head_out), 64'd2);
        checkOutput("lit_full_retire_reject", 64'(free_slots_out), 64'd2);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_next_accept_tags", 64'(dispatch_tag_out), 64'b001_000);
        tick();
        checkOutput("lit_refill_free", 64'(free_slots_out), 64'd0);
        drainAll();
        checkOutput("lit_drained_free", 64'(free_slots_out), 64'd8);

        // Wrap: bring tail to 7, dispatch lane1 only, then a full group.
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_wrap_lane1_tag", 64'(dispatch_tag_out[5:3]), 64'd7);
        tick();
        checkOutput("lit_wrap_tail", 64'(tail_out), 64'd0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_wrap_next_tags", 64'(dispatch_tag_out), 64'b001_000);
        tick();
        drainAll();

        // Mispredict at head with a done younger entry behind it.
        applyStimulus(2'b11, 2'b01, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        br_pc = pc_in[31:0];
        tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 6'b011_010, 2'b01, 1'b0); tick();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b01, 6'b000_011, 2'b00, 1'b0);
        checkOutput("lit_mispred", 64'(mispred_out), 64'd1);
        checkOutput("lit_mispred_rv", 64'(retire_valid_out), 64'b01);
        checkOutput("lit_mispred_pc", 64'(mispred_pc_out), 64'(br_pc));
        tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_flush_head", 64'(head_out), 64'd0);
        checkOutput("lit_flush_tail", 64'(tail_out), 64'd0);
        checkOutput("lit_flush_free", 64'(free_slots_out), 64'd8);
        tick();

        // Both buses hit tag 3; bus 0 (taken) must win against pred_taken=0.
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        applyStimulus(2'b11, 2'b10, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 6'b011_011, 2'b01, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 6'b001_000, 2'b00, 1'b0); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 6'b000_010, 2'b00, 1'b0);
        checkOutput("lit_pair_retire", 64'(retire_valid_out), 64'b11);
        tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_samecdb_mispred", 64'(mispred_out), 64'd1);
        checkOutput("lit_samecdb_rv", 64'(retire_valid_out), 64'b11);
        tick();

        // Reset with five live entries and a dispatch in flight.
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0); tick();
        checkOutput("lit_five_free", 64'(free_slots_out), 64'd3);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b01, 6'b000_000, 2'b00, 1'b1); tick();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 6'b0, 2'b00, 1'b0);
        checkOutput("lit_rst_free", 64'(free_slots_out), 64'd8);
        checkOutput("lit_rst_head", 64'(head_out), 64'd0);
        checkOutput("lit_rst_tail", 64'(tail_out), 64'd0);
        checkOutput("lit_rst_full", 64'(full_out), 64'd0);
        checkOutput("lit_rst_rv", 64'(retire_valid_out), 64'd0);
        checkOutput("lit_rst_mispred", 64'(mispred_out), 64'd0);
        checkOutput("lit_rst_mispc", 64'(mispred_pc_out), 64'd0);
        checkOutput("lit_rst_rpc", retire_pc_out, 64'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
